level_ctrl: RTL
===============

# level_ctrl

Upstream stage of the 15-segment thermometer bar decoder. It turns two raw push-buttons into a 4-bit saturating level `x2` in the range 0–15. The level decays over time and locks briefly at full scale. `x2` connects directly to the decoder's 4-bit input.

## Interface
- `DEB_CYCLES`, default 1_000_000: number of consecutive stable synchronized samples required before the debounced button state flips. Minimum 2.
- `DECAY_TICKS`, default 50_000_000: clock cycles per decay period. Minimum 2.
- `LOCK_PERIODS`, default 3: number of decay periods the level is held at 15 after reaching it. Minimum 1.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_up` in 1: raw, asynchronous, bouncy "add" button.
- `btn_down` in 1: raw, asynchronous, bouncy "remove" button.
- `decay_en` in 1: synchronous level input; when 1, automatic decay is enabled.
- `x2` out 4: current level; feeds the bar decoder.
- `full` out 1: high exactly when `x2 == 15`.
- `empty` out 1: high exactly when `x2 == 0`.
- `locked` out 1: high while the FSM is in LOCK.

## Operation
- **Button conditioning (per button):**
  - 2-flop synchronizer.
  - Debounce counter: counts cycles in which the synced value differs from the debounced state, and clears whenever they match. When the count reaches `DEB_CYCLES`, the debounced state takes the synced value.
  - Press pulse: one cycle high on the 0→1 transition of the debounced state. Releases generate nothing.
- **FSM states:**
  - IDLE: `x2 == 0`; timer stopped and cleared.
  - RUN: `0 < x2 < 15`.
  - LOCK: `x2 == 15`.
- **Transitions:**
  - IDLE → RUN on an accepted up-press; `x2` becomes 1.
  - RUN → LOCK when `x2` becomes 15; the lock period counter clears.
  - RUN → IDLE when `x2` becomes 0, whether by down-press or by decay.
  - LOCK → RUN after `LOCK_PERIODS` full decay periods; `x2` becomes 14 on that same edge. This happens regardless of `decay_en`.
- **Level arithmetic:**
  - Unsigned 4-bit, saturating. Up-press at 15 does nothing; down-press at 0 does nothing.
  - Never wraps.
- **Simultaneous up and down press in the same cycle:** no change, and the timer is not restarted.
- **Decay timer:**
  - Counts 0 to `DECAY_TICKS-1` in RUN and LOCK.
  - At terminal count in RUN with `decay_en == 1`: `x2` decrements by 1.
  - In LOCK, terminal count increments the lock period counter.
  - Any accepted single press (in RUN) restarts the timer at 0. If a press and a terminal count land on the same edge, the press is applied and the decay step is discarded.
  - With `decay_en == 0` in RUN, the timer holds at 0.
- **In LOCK:** both presses are ignored.
- **Reset (asserted at any time, including mid-debounce or mid-LOCK):**
  - `x2 = 0`, `full = 0`, `empty = 1`, `locked = 0`.
  - FSM in IDLE.
  - All counters, synchronizers and debounced states at 0.
  - No press pulse is generated on reset release, even if a button is held. The debounced state must first reach 1 through the full debounce window.

## Timing
- **Press latency:** button input high and stable, first sampled at edge E. `x2` updates at edge E + `DEB_CYCLES` + 3. This covers 2 sync stages, the debounce window, edge detection and the level register.
- **Decay step:** `x2` decrements exactly `DECAY_TICKS` cycles after the last timer restart, or after the previous decay step.
- **Flag timing:** `full`, `empty` and `locked` are registered and change on the same edge as `x2`. They are never out of step with it.
- **LOCK duration:** exactly `LOCK_PERIODS × DECAY_TICKS` cycles from entry to the edge where `x2` becomes 14.

## Structure
- Package `level_pkg`:
  - State enum: IDLE, RUN, LOCK.
  - `LEVEL_MAX = 4'd15`, `LEVEL_MIN = 4'd0`.
- Sub-module `btn_conditioner`:
  - Parameter: `DEB_CYCLES`.
  - Ports: `clk`, `rst_n`, `btn_raw` → `press`.
  - Instantiated once for `btn_up` and once for `btn_down`.
- Top level holds the FSM, decay timer, lock counter and level register.

## Test plan
All scenarios use `DEB_CYCLES=4`, `DECAY_TICKS=10`, `LOCK_PERIODS=2`.
- **Clean press:** hold `btn_up` high from reset idle → `x2` goes 0→1 exactly 7 cycles after the first sampling edge; `empty` falls on the same edge; exactly one increment per hold.
- **Bounce:** toggle `btn_up` every 2 cycles for 20 cycles, then release → `x2` stays 0.
- **Saturation and lock:** 15 presses with `decay_en=0` → `x2=15`, `full=1`, `locked=1`. A 16th press and a down-press are ignored. After 20 cycles `x2=14` and `locked=0`.
- **Decay and restart:** `x2=3`, `decay_en=1` → `x2` is 2 after 10 cycles, 1 after 20, then 0 with `empty=1` and IDLE. Repeat with an up-press landing on a terminal count → `x2` increments, no decrement, next decay 10 cycles later.
- **Simultaneous presses:** up and down press pulses in the same cycle at `x2=5` → `x2` stays 5 and the timer is not restarted.
- **Reset mid-LOCK:** assert `rst_n=0` asynchronously mid-LOCK while `btn_up` is held → outputs immediately show `x2=0`, `empty=1`, `locked=0`. After release, the first increment comes 7 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/level_pkg.sv
// Shared types and constants for the button-driven level controller.
// The controller states map one-to-one onto level ranges: IDLE is empty, RUN is partial and LOCK is full.
package level_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOCK
  } state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;
  localparam logic [3:0] LEVEL_MIN = 4'd0;

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises and debounces one raw push-button.
// It emits a single-cycle press pulse when the debounced state rises.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic          debPrev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter only advances while the synced value disagrees with the debounced state.
  // The DEB_CYCLES-th consecutive disagreement commits the new value.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      debPrev_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      press_q   <= deb_q & ~debPrev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/level_ctrl.sv
// Saturating 0..15 level driven by up/down buttons, with timed decay and a hold period at full scale.
// x2 feeds the thermometer bar decoder directly.
module level_ctrl
  import level_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1_000_000,
  parameter int unsigned DECAY_TICKS  = 50_000_000,
  parameter int unsigned LOCK_PERIODS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       decay_en,
  output logic [3:0] x2,
  output logic       full,
  output logic       empty,
  output logic       locked
);

  localparam int unsigned TW = $clog2(DECAY_TICKS);
  localparam int unsigned LW = $clog2(LOCK_PERIODS + 1);

  logic          upPress;
  logic          downPress;
  logic          singleUp;
  logic          singleDown;
  logic          termCnt;
  state_t        state_q;
  state_t        state_d;
  logic [3:0]    level_q;
  logic [3:0]    level_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic [LW-1:0] lockCnt_q;
  logic [LW-1:0] lockCnt_d;
  logic          full_q;
  logic          empty_q;
  logic          locked_q;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) uUpBtn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_up),
    .press  (upPress)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) uDownBtn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_down),
    .press  (downPress)
  );

  // Coincident up and down pulses cancel and behave as no press at all.
  assign singleUp   = upPress & ~downPress;
  assign singleDown = downPress & ~upPress;
  assign termCnt    = (timer_q == TW'(DECAY_TICKS - 1));

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    timer_d   = timer_q;
    lockCnt_d = lockCnt_q;
    case (state_q)
      IDLE: begin
        timer_d   = '0;
        lockCnt_d = '0;
        if (singleUp) begin
          level_d = LEVEL_MIN + 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        // A press wins over a coincident decay step and restarts the period.
        if (singleUp) begin
          level_d = level_q + 4'd1;
          timer_d = '0;
          if (level_q == LEVEL_MAX - 4'd1) begin
            state_d   = LOCK;
            lockCnt_d = '0;
          end
        end else if (singleDown) begin
          level_d = level_q - 4'd1;
          timer_d = '0;
          if (level_q == LEVEL_MIN + 4'd1) begin
            state_d = IDLE;
          end
        end else if (!decay_en) begin
          timer_d = '0;
        end else if (termCnt) begin
          timer_d = '0;
          level_d = level_q - 4'd1;
          if (level_q == LEVEL_MIN + 4'd1) begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LOCK: begin
        // The timer keeps running here even with decay disabled, so the hold always expires.
        if (termCnt) begin
          timer_d = '0;
          if (lockCnt_q == LW'(LOCK_PERIODS - 1)) begin
            state_d = RUN;
            level_d = LEVEL_MAX - 4'd1;
          end else begin
            lockCnt_d = lockCnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= LEVEL_MIN;
      timer_q   <= '0;
      lockCnt_q <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
      lockCnt_q <= lockCnt_d;
      full_q    <= (level_d == LEVEL_MAX);
      empty_q   <= (level_d == LEVEL_MIN);
      locked_q  <= (state_d == LOCK);
    end
  end

  assign x2     = level_q;
  assign full   = full_q;
  assign empty  = empty_q;
  assign locked = locked_q;

endmodule
